// File: rtl/ahb_arb_slave_7.sv
// Round-robin AHB arbiter in front of slave_7.
// Grants one master at a time (sel), tracks the data-phase owner (sel_d),
// holds locked tenures, and preempts long unlocked bursts after MAX_HOLD beats
// when another master is waiting.
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | no owner, sel all-zero
// ST_OWN  | one owner, unlocked tenure (preemptible)
// ST_LOCK | one owner, locked tenure (held until unlock)
module ahb_arb_slave_7 #(
  parameter int CHANNEL_NUM = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [CHANNEL_NUM-1:0]   hreq,
  input  logic [CHANNEL_NUM-1:0]   hlock,
  input  logic [2*CHANNEL_NUM-1:0] htrans,
  input  logic                     hready_in,
  output logic [CHANNEL_NUM-1:0]   sel,
  output logic [CHANNEL_NUM-1:0]   sel_d,
  output logic                     locked
);

  localparam int IW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_LOCK} state_t;

  state_t                 state_q;
  logic [CHANNEL_NUM-1:0] sel_q;
  logic [CHANNEL_NUM-1:0] sel_d_q;
  logic [IW-1:0]          last_q;
  logic [CW-1:0]          cnt_q;
  logic                   locked_q;

  logic [1:0]             owner_trans;
  logic                   boundary;
  logic                   others_req;
  logic                   arb;
  logic                   found;
  logic [IW-1:0]          gnt_idx;
  logic [CHANNEL_NUM-1:0] gnt_vec;

  // The owner is always last_q while a tenure is active, since the pointer
  // follows every grant.
  // Decide whether this edge is an arbitration point and pick the next owner.
  always_comb begin
    owner_trans = htrans[{last_q, 1'b0} +: 2];
    boundary    = (owner_trans == 2'b00) || (owner_trans == 2'b10);
    others_req  = |(hreq & ~sel_q);
    arb         = 1'b1;
    unique case (state_q)
      ST_IDLE: arb = 1'b1;
      ST_OWN:  arb = boundary || ((cnt_q == CW'(MAX_HOLD)) && others_req);
      ST_LOCK: arb = boundary && !hlock[last_q];
      default: arb = 1'b1;
    endcase

    found   = 1'b0;
    gnt_idx = last_q;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      int idx;
      idx = (int'(last_q) + k) % CHANNEL_NUM;
      if (!found && hreq[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    gnt_vec          = '0;
    gnt_vec[gnt_idx] = 1'b1;
  end

  // Arbiter state, registered outputs, hold counter and priority pointer;
  // everything freezes while the slave stalls.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      sel_d_q  <= '0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
      last_q   <= IW'(CHANNEL_NUM - 1);
    end else if (hready_in) begin
      sel_d_q <= sel_q;
      if (arb) begin
        cnt_q <= '0;
        if (found) begin
          sel_q  <= gnt_vec;
          last_q <= gnt_idx;
          if (hlock[gnt_idx]) begin
            state_q  <= ST_LOCK;
            locked_q <= 1'b1;
          end else begin
            state_q  <= ST_OWN;
            locked_q <= 1'b0;
          end
        end else begin
          state_q  <= ST_IDLE;
          sel_q    <= '0;
          locked_q <= 1'b0;
        end
      end else if (owner_trans[1] && (cnt_q != CW'(MAX_HOLD))) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sel    = sel_q;
  assign sel_d  = sel_d_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_ahb_arb_slave_7.sv
// Self-checking bench for ahb_arb_slave_7: directed scenarios followed by
// random traffic, all checked against a tenure-level reference model.
module tb_ahb_arb_slave_7;

  localparam int N  = 2;
  localparam int MH = 16;

  logic           HCLK = 1'b0;
  logic           HRESET;
  logic [N-1:0]   hreq;
  logic [N-1:0]   hlock;
  logic [2*N-1:0] htrans;
  logic           hready_in;
  logic [N-1:0]   sel;
  logic [N-1:0]   sel_d;
  logic           locked;

  int tests = 0;
  int fails = 0;

  // reference model: owner index (-1 = none), data-phase owner, lock flag,
  // accepted-beat count of the tenure, round-robin pointer
  int m_owner;
  int m_seld;
  bit m_lk;
  int m_cnt;
  int m_last;

  ahb_arb_slave_7 #(.CHANNEL_NUM(N), .MAX_HOLD(MH)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .hreq(hreq), .hlock(hlock),
    .htrans(htrans), .hready_in(hready_in),
    .sel(sel), .sel_d(sel_d), .locked(locked)
  );

  always #5 HCLK = ~HCLK;

  function automatic int vec_of(input int o);
    return (o < 0) ? 0 : (1 << o);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock edge of the arbitration rules, applied to the model.
  task automatic model_edge();
    int  tr;
    int  g;
    bit  bnd;
    bit  others;
    bit  arbp;
    if (HRESET) begin
      m_owner = -1; m_seld = -1; m_lk = 0; m_cnt = 0; m_last = N - 1;
      return;
    end
    if (!hready_in) return;
    m_seld = m_owner;
    tr     = (m_owner < 0) ? 0 : int'((htrans >> (2 * m_owner)) & 3);
    bnd    = (tr == 0) || (tr == 2);
    others = (m_owner >= 0) && ((int'(hreq) & ~vec_of(m_owner)) != 0);
    if (m_owner < 0)  arbp = 1;
    else if (m_lk)    arbp = bnd && !hlock[m_owner];
    else              arbp = bnd || (m_cnt == MH && others);
    if (arbp) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && hreq[(m_last + k) % N]) g = (m_last + k) % N;
      end
      m_cnt = 0;
      if (g >= 0) begin
        m_owner = g; m_last = g; m_lk = hlock[g];
      end else begin
        m_owner = -1; m_lk = 0;
      end
    end else if (tr >= 2 && m_cnt < MH) begin
      m_cnt++;
    end
  endtask

  task automatic step(input string tag);
    @(posedge HCLK);
    model_edge();
    #1;
    chk({tag, ".sel"},    32'(sel),    32'(vec_of(m_owner)));
    chk({tag, ".sel_d"},  32'(sel_d),  32'(vec_of(m_seld)));
    chk({tag, ".locked"}, 32'(locked), 32'(m_lk));
    chk({tag, ".onehot"}, 32'($onehot0(sel) && $onehot0(sel_d)), 32'd1);
  endtask

  initial begin
    m_owner = -1; m_seld = -1; m_lk = 0; m_cnt = 0; m_last = N - 1;
    HRESET = 1'b1; hreq = '0; hlock = '0; htrans = '0; hready_in = 1'b1;
    step("rst0");
    step("rst1");
    chk("rst.sel", 32'(sel), 32'd0);
    chk("rst.locked", 32'(locked), 32'd0);

    // first grant after reset goes to master 0, sel_d follows a beat later
    HRESET = 1'b0; hreq = 2'b11; htrans = 4'b1010;
    step("first_grant");
    chk("first_grant.sel0", 32'(sel), 32'd1);
    step("first_data");
    chk("first_data.seld0", 32'(sel_d), 32'd1);

    // master 0 holds for a 4-beat SEQ burst, hands over on IDLE
    HRESET = 1'b1; step("rst_b");
    HRESET = 1'b0; hreq = 2'b11; htrans = 4'b0010;
    step("burst_grant");
    htrans = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step("burst_seq");
      chk("burst_seq.hold", 32'(sel), 32'd1);
    end
    htrans = 4'b0000;
    step("burst_end");
    chk("burst_end.handover", 32'(sel), 32'd2);

    // stall during a handover: everything frozen until hready_in returns
    hready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.sel", 32'(sel), 32'd2);
      chk("stall.sel_d", 32'(sel_d), 32'd1);
    end
    hready_in = 1'b1;
    step("stall_release");
    chk("stall_release.sel", 32'(sel), 32'd1);
    chk("stall_release.sel_d", 32'(sel_d), 32'd2);

    // locked tenure of master 1 ignores master 0 and the hold limit
    HRESET = 1'b1; step("rst_l");
    HRESET = 1'b0; hreq = 2'b10; hlock = 2'b10; htrans = 4'b1000;
    step("lock_grant");
    chk("lock_grant.locked", 32'(locked), 32'd1);
    hreq = 2'b11; htrans = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      step("lock_seq");
      chk("lock_seq.sel", 32'(sel), 32'd2);
      chk("lock_seq.locked", 32'(locked), 32'd1);
    end
    hlock = 2'b00; htrans = 4'b0010;
    step("unlock");
    chk("unlock.sel", 32'(sel), 32'd1);
    chk("unlock.locked", 32'(locked), 32'd0);

    // unlocked burst preempted after MAX_HOLD accepted beats
    HRESET = 1'b1; step("rst_h");
    HRESET = 1'b0; hreq = 2'b01; hlock = 2'b00; htrans = 4'b0010;
    step("hold_grant");
    hreq = 2'b11; htrans = 4'b1111;
    for (int i = 1; i <= 20; i++) begin
      step("hold_seq");
      if (i == MH)     chk("hold.before_limit", 32'(sel), 32'd1);
      if (i == MH + 1) chk("hold.preempted", 32'(sel), 32'd2);
    end

    // reset in the middle of a locked tenure
    HRESET = 1'b1; step("rst_m");
    HRESET = 1'b0; hreq = 2'b10; hlock = 2'b10; htrans = 4'b1000;
    step("ml_grant");
    htrans = 4'b1100;
    for (int i = 0; i < 3; i++) step("ml_seq");
    HRESET = 1'b1;
    step("ml_reset");
    chk("ml_reset.sel", 32'(sel), 32'd0);
    chk("ml_reset.sel_d", 32'(sel_d), 32'd0);
    chk("ml_reset.locked", 32'(locked), 32'd0);
    HRESET = 1'b0; hreq = 2'b11; hlock = 2'b00; htrans = 4'b1010;
    step("ml_after");
    chk("ml_after.sel", 32'(sel), 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      HRESET    = ($urandom_range(0, 99) == 0);
      hreq      = N'($urandom);
      hlock     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      htrans    = ($urandom_range(0, 2) != 0) ? {N{2'b11}} : (2*N)'($urandom);
      hready_in = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
